// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter for 32 requesters driving the 5-bit select of a 32:1 mux.
// A grant is held until release, request drop, or the optional HOLD_MAX limit expires.
module rr_arbiter_32 #(
   parameter int HOLD_MAX = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] req,
   input  logic        release_hold,
   output logic        grant_valid,
   output logic [4:0]  grant_sel,
   output logic [31:0] grant_onehot,
   output logic        timeout
);

   localparam int CNT_W = $clog2(HOLD_MAX + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state;
   logic [4:0]       last;
   logic [CNT_W-1:0] cnt;

   logic       found;
   logic [4:0] winner;
   logic [4:0] idx;
   logic       holder_done;
   logic       hit_limit;

   // Scan from the farthest offset back to last+1 so the nearest requester wins;
   // offset 32 wraps to last itself, letting a lone requester win again.
   always_comb begin
      found  = 1'b0;
      winner = last;
      idx    = last;
      for (int i = 32; i >= 1; i--) begin
         idx = last + 5'(i);
         if (req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign holder_done = release_hold || !req[grant_sel];
   assign hit_limit   = (HOLD_MAX != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         grant_valid  <= 1'b0;
         grant_sel    <= 5'd0;
         grant_onehot <= 32'd0;
         timeout      <= 1'b0;
         last         <= 5'd31;
         cnt          <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state        <= GRANT;
                  grant_valid  <= 1'b1;
                  grant_sel    <= winner;
                  grant_onehot <= 32'd1 << winner;
                  last         <= winner;
                  cnt          <= '0;
               end
            end
            GRANT: begin
               // Release and request drop outrank the hold limit for the timeout flag.
               if (holder_done || hit_limit) begin
                  state        <= IDLE;
                  grant_valid  <= 1'b0;
                  grant_onehot <= 32'd0;
                  timeout      <= !holder_done;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Bench for rr_arbiter_32: two instances (no hold limit, HOLD_MAX=4) share stimulus
// and are compared every cycle with a cycle-count based round-robin model.
module tb_rr_arbiter_32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] req = 32'd0;
   logic        release_hold = 1'b0;

   logic        gv0, to0, gv1, to1;
   logic [4:0]  gs0, gs1;
   logic [31:0] go0, go1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   rr_arbiter_32 #(.HOLD_MAX(0)) dut0 (
      .clock(clock), .reset(reset), .req(req), .release_hold(release_hold),
      .grant_valid(gv0), .grant_sel(gs0), .grant_onehot(go0), .timeout(to0));

   rr_arbiter_32 #(.HOLD_MAX(4)) dut1 (
      .clock(clock), .reset(reset), .req(req), .release_hold(release_hold),
      .grant_valid(gv1), .grant_sel(gs1), .grant_onehot(go1), .timeout(to1));

   wire [38:0] out0 = {gv0, gs0, go0, to0};
   wire [38:0] out1 = {gv1, gs1, go1, to1};

   // Reference model: holder index, cycles held so far, last winner.
   int hm     [2] = '{0, 4};
   bit m_busy [2] = '{0, 0};
   bit m_to   [2] = '{0, 0};
   int m_sel  [2] = '{0, 0};
   int m_last [2] = '{31, 31};
   int m_len  [2] = '{0, 0};

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         m_to[k] = 0;
         if (reset) begin
            m_busy[k] = 0; m_sel[k] = 0; m_last[k] = 31; m_len[k] = 0;
         end else if (!m_busy[k]) begin
            for (int s = 1; s <= 32; s++) begin
               if (!m_busy[k] && req[(m_last[k] + s) % 32]) begin
                  m_busy[k] = 1;
                  m_sel[k]  = (m_last[k] + s) % 32;
                  m_last[k] = m_sel[k];
                  m_len[k]  = 1;
               end
            end
         end else begin
            if (release_hold || !req[m_sel[k]]) m_busy[k] = 0;
            else if (hm[k] != 0 && m_len[k] == hm[k]) begin
               m_busy[k] = 0; m_to[k] = 1;
            end else m_len[k]++;
         end
      end
   end

   function automatic logic [38:0] exp_vec(int k);
      logic [31:0] oh;
      oh = m_busy[k] ? (32'd1 << m_sel[k]) : 32'd0;
      return {m_busy[k], 5'(m_sel[k]), oh, m_to[k]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 32'd0; release_hold = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (out0 !== 39'd0) begin
         n_fail++; $display("FAIL reset_dut0 got %h want 0", out0);
      end
      n_checks++;
      if (out1 !== 39'd0) begin
         n_fail++; $display("FAIL reset_dut1 got %h want 0", out1);
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 32'h0000_0001;
      tick();
      n_checks++;
      if ({gv0, gs0, go0} !== {1'b1, 5'd0, 32'h1}) begin
         n_fail++; $display("FAIL single_first got %b/%0d/%h want 1/0/1", gv0, gs0, go0);
      end
      for (int c = 0; c < 40; c++) begin
         tick();
         n_checks++;
         if (out0 !== exp_vec(0) || gv0 !== 1'b1) begin
            n_fail++; $display("FAIL single_hold0 cyc %0d got %h want %h", c, out0, exp_vec(0));
         end
         n_checks++;
         if (out1 !== exp_vec(1)) begin
            n_fail++; $display("FAIL single_hold1 cyc %0d got %h want %h", c, out1, exp_vec(1));
         end
      end
   endtask

   task automatic test_rotation();
      int nxt = 0;
      do_reset();
      req = 32'hFFFF_FFFF; release_hold = 1'b1;
      for (int t = 0; t < 66; t++) begin
         tick();
         n_checks++;
         if (gv0 !== ((t % 2) == 0)) begin
            n_fail++; $display("FAIL rot_valid t %0d got %b want %b", t, gv0, (t % 2) == 0);
         end
         if (gv0) begin
            n_checks++;
            if (gs0 !== 5'(nxt)) begin
               n_fail++; $display("FAIL rot_sel t %0d got %0d want %0d", t, gs0, nxt % 32);
            end
            nxt = (nxt + 1) % 32;
         end
         n_checks++;
         if (out1 !== exp_vec(1)) begin
            n_fail++; $display("FAIL rot_dut1 t %0d got %h want %h", t, out1, exp_vec(1));
         end
      end
      release_hold = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      req = 32'd1 << 5;
      tick();
      release_hold = 1'b1;
      tick();
      release_hold = 1'b0;
      req = (32'd1 << 3) | (32'd1 << 20);
      tick();
      n_checks++;
      if ({gv0, gs0} !== {1'b1, 5'd20} || out0 !== exp_vec(0)) begin
         n_fail++; $display("FAIL prio_first got %b/%0d want 1/20", gv0, gs0);
      end
      release_hold = 1'b1;
      tick();
      release_hold = 1'b0;
      tick();
      n_checks++;
      if ({gv0, gs0, go0} !== {1'b1, 5'd3, 32'h8} || out1 !== exp_vec(1)) begin
         n_fail++; $display("FAIL prio_second got %b/%0d/%h want 1/3/8", gv0, gs0, go0);
      end
   endtask

   task automatic test_timeout();
      int held = 0;
      do_reset();
      req = 32'd1 << 7;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (gv1 && !to1) held++;
      end
      n_checks++;
      if (held != 4) begin
         n_fail++; $display("FAIL to_len got %0d want 4", held);
      end
      tick();
      n_checks++;
      if ({gv1, to1, gs1} !== {1'b0, 1'b1, 5'd7}) begin
         n_fail++; $display("FAIL to_revoke got v%b t%b s%0d want v0 t1 s7", gv1, to1, gs1);
      end
      tick();
      n_checks++;
      if ({gv1, to1, gs1} !== {1'b1, 1'b0, 5'd7} || out0 !== exp_vec(0)) begin
         n_fail++; $display("FAIL to_regrant got v%b t%b s%0d want v1 t0 s7", gv1, to1, gs1);
      end
      tick(); tick(); tick();
      release_hold = 1'b1;
      tick();
      release_hold = 1'b0;
      n_checks++;
      if ({gv1, to1} !== 2'b00 || out1 !== exp_vec(1)) begin
         n_fail++; $display("FAIL to_release got v%b t%b want v0 t0", gv1, to1);
      end
   endtask

   task automatic test_drop();
      do_reset();
      req = 32'd1 << 12;
      tick(); tick();
      req = 32'd0;
      tick();
      n_checks++;
      if ({gv0, to0, gs0, go0} !== {1'b0, 1'b0, 5'd12, 32'd0}) begin
         n_fail++; $display("FAIL drop0 got v%b t%b s%0d o%h want v0 t0 s12 o0", gv0, to0, gs0, go0);
      end
      n_checks++;
      if ({gv1, to1, gs1} !== {1'b0, 1'b0, 5'd12}) begin
         n_fail++; $display("FAIL drop1 got v%b t%b s%0d want v0 t0 s12", gv1, to1, gs1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 32'd1 << 9;
      tick(); tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if (out0 !== 39'd0 || out1 !== 39'd0) begin
         n_fail++; $display("FAIL rstmid got %h %h want 0 0", out0, out1);
      end
      reset = 1'b0;
      req = 32'hFFFF_FFFF;
      tick();
      n_checks++;
      if ({gv0, gs0, go0} !== {1'b1, 5'd0, 32'h1}) begin
         n_fail++; $display("FAIL rstmid_first got %b/%0d/%h want 1/0/1", gv0, gs0, go0);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         case ($urandom_range(0, 3))
            0: req = $urandom;
            1: req = 32'd1 << $urandom_range(0, 31);
            2: req = $urandom & $urandom & $urandom;
            default: ;
         endcase
         release_hold = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 99) == 0);
         tick();
         n_checks++;
         if (out0 !== exp_vec(0)) begin
            n_fail++; $display("FAIL rand_dut0 cyc %0d got %h want %h", c, out0, exp_vec(0));
         end
         n_checks++;
         if (out1 !== exp_vec(1)) begin
            n_fail++; $display("FAIL rand_dut1 cyc %0d got %h want %h", c, out1, exp_vec(1));
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_priority();
      test_timeout();
      test_drop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
